seg_display_ctrl: RTL

//  Memory-mapped 8-digit seven-segment display controller; sits directly downstream of the

---
 rtl/seg_display_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: memory-mapped 8-digit seven-segment display controller.
// Holds a 32-bit hex value and a 2-bit control register {LZS, EN}. Digits are
// time-multiplexed, and each slot opens with a blank gap so that the previous
// digit's segment pattern does not ghost onto the newly selected anode.
module seg_display_ctrl #(
    parameter int SCAN_DIV  = 100000,  // clk cycles per digit slot
    parameter int BLANK_CYC = 1000     // all-anodes-off cycles at slot start
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        seg_cs,
    input  logic [1:0]  seg_addr,
    input  logic [15:0] seg_wdata,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_out
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);

    logic [31:0]      r_value;
    logic [1:0]       r_ctrl;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_an;
    logic [7:0]       r_seg;

    logic             w_en;
    logic             w_lzs;
    logic [3:0]       w_nibble;
    logic [7:0]       w_upper_zero;
    logic [7:0]       w_an_nxt;
    logic [7:0]       w_seg_nxt;

    assign w_en     = r_ctrl[0];
    assign w_lzs    = r_ctrl[1];
    assign w_nibble = r_value[{r_idx, 2'b00} +: 4];

    // w_upper_zero[i]: this digit and every digit to its left are zero.
    // Digit 0 never qualifies so a value of zero still shows a single "0".
    assign w_upper_zero[0] = 1'b0;
    for (genvar gi = 1; gi < 8; gi++) begin : g_uz
        assign w_upper_zero[gi] = (r_value[31:4*gi] == '0);
    end

    // Active-low {dp,g,f,e,d,c,b,a}; dp stays off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_to_seg = 8'hC0;
            4'h1: hex_to_seg = 8'hF9;
            4'h2: hex_to_seg = 8'hA4;
            4'h3: hex_to_seg = 8'hB0;
            4'h4: hex_to_seg = 8'h99;
            4'h5: hex_to_seg = 8'h92;
            4'h6: hex_to_seg = 8'h82;
            4'h7: hex_to_seg = 8'hF8;
            4'h8: hex_to_seg = 8'h80;
            4'h9: hex_to_seg = 8'h90;
            4'hA: hex_to_seg = 8'h88;
            4'hB: hex_to_seg = 8'h83;
            4'hC: hex_to_seg = 8'hC6;
            4'hD: hex_to_seg = 8'hA1;
            4'hE: hex_to_seg = 8'h86;
            default: hex_to_seg = 8'h8E;
        endcase
    endfunction

    // Register file: value halves and control; address 11 is a no-op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
            r_ctrl  <= 2'b01;
        end else if (seg_cs) begin
            case (seg_addr)
                2'b00:   r_value[15:0]  <= seg_wdata;
                2'b01:   r_value[31:16] <= seg_wdata;
                2'b10:   r_ctrl         <= seg_wdata[1:0];
                default: ;
            endcase
        end
    end

    // Slot timer and digit index; parked at 0 while disabled so that
    // re-enabling always begins with digit 0 at the start of its slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (!w_en) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (r_cnt == CNT_MAX) begin
            r_cnt <= '0;
            r_idx <= r_idx + 3'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Next output pattern: dark unless enabled, past the blank gap and not
    // a suppressed leading zero. At most one anode bit is ever low.
    always_comb begin
        w_an_nxt  = 8'hFF;
        w_seg_nxt = 8'hFF;
        if (w_en && !(r_cnt < BLANK_LIM) && !(w_lzs && w_upper_zero[r_idx])) begin
            w_an_nxt  = ~(8'b1 << r_idx);
            w_seg_nxt = hex_to_seg(w_nibble);
        end
    end

    // Registered outputs: the whole digit changes on one edge, never torn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= 8'hFF;
            r_seg <= 8'hFF;
        end else begin
            r_an  <= w_an_nxt;
            r_seg <= w_seg_nxt;
        end
    end

    assign seg_an  = r_an;
    assign seg_out = r_seg;

endmodule
